// File: rtl/sfpp_reconfig_pkg.sv
// rtl/sfpp_reconfig_pkg.sv - shared framing constants and decoder state for the reconfig byte path
//
// Purpose: in-band framing marker values and the bytes-to-packets decoder
//          state encoding, shared by the decoder and the packet-to-bytes encoder.
// Ports:   none (package).
package sfpp_reconfig_pkg;

  localparam logic [7:0] MARK_SOP  = 8'h7A;
  localparam logic [7:0] MARK_EOP  = 8'h7B;
  localparam logic [7:0] MARK_CHAN = 8'h7C;
  localparam logic [7:0] MARK_ESC  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ESC      = 2'd1,
    CHAN     = 2'd2,
    CHAN_ESC = 2'd3
  } b2p_state_e;

endpackage

// File: rtl/sfpp_reconfig_b2p_decoder.sv
// rtl/sfpp_reconfig_b2p_decoder.sv - bytes-to-packets decoder for the reconfig command byte stream
//
// Purpose: strips SOP/EOP/channel/escape markers from the framed byte stream
//          and emits unescaped data bytes with packet and channel sideband
//          through a single output register stage. Data bytes seen outside a
//          packet are dropped and counted in a saturating counter.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   in_valid, in_data, in_ready  - framed byte stream in
//   out_valid, out_data, out_channel, out_startofpacket, out_endofpacket,
//   out_ready                    - decoded packet byte stream out
//   drop_count                   - saturating count of dropped out-of-packet bytes
module sfpp_reconfig_b2p_decoder
  import sfpp_reconfig_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic [CHANNEL_WIDTH-1:0]  out_channel,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  input  logic                      out_ready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  b2p_state_e               state, state_n;
  logic                     sop_pend, sop_pend_n;
  logic                     eop_pend, eop_pend_n;
  logic                     in_packet, in_packet_n;
  logic [CHANNEL_WIDTH-1:0] chan_reg, chan_reg_n;

  logic       accept;
  logic       is_data;
  logic [7:0] data_byte;
  logic       emit;
  logic       drop;

  // Single register stage: a new byte may enter whenever the held one leaves.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n     = state;
    sop_pend_n  = sop_pend;
    eop_pend_n  = eop_pend;
    in_packet_n = in_packet;
    chan_reg_n  = chan_reg;
    is_data     = 1'b0;
    data_byte   = in_data;

    if (accept) begin
      case (state)
        NORMAL: begin
          if (in_data == MARK_SOP) begin
            sop_pend_n = 1'b1;
          end else if (in_data == MARK_EOP) begin
            eop_pend_n = 1'b1;
          end else if (in_data == MARK_CHAN) begin
            state_n = CHAN;
          end else if (in_data == MARK_ESC) begin
            state_n = ESC;
          end else begin
            is_data = 1'b1;
          end
        end
        ESC: begin
          is_data   = 1'b1;
          data_byte = in_data ^ ESC_XOR;
          state_n   = NORMAL;
        end
        CHAN: begin
          if (in_data == MARK_ESC) begin
            state_n = CHAN_ESC;
          end else begin
            chan_reg_n = CHANNEL_WIDTH'(in_data);
            state_n    = NORMAL;
          end
        end
        CHAN_ESC: begin
          chan_reg_n = CHANNEL_WIDTH'(in_data ^ ESC_XOR);
          state_n    = NORMAL;
        end
        default: state_n = NORMAL;
      endcase
    end

    emit = is_data && (in_packet || sop_pend);
    drop = is_data && !emit;

    if (emit) begin
      sop_pend_n = 1'b0;
      eop_pend_n = 1'b0;
      // EOP wins so a byte carrying both SOP and EOP leaves us outside a packet.
      if (sop_pend) in_packet_n = 1'b1;
      if (eop_pend) in_packet_n = 1'b0;
    end

    // An EOP marker that only precedes a dropped byte must not leak into the next packet.
    if (drop) begin
      eop_pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NORMAL;
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
      in_packet <= 1'b0;
      chan_reg  <= '0;
    end else begin
      state     <= state_n;
      sop_pend  <= sop_pend_n;
      eop_pend  <= eop_pend_n;
      in_packet <= in_packet_n;
      chan_reg  <= chan_reg_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (emit) begin
      out_valid         <= 1'b1;
      out_data          <= data_byte;
      out_channel       <= chan_reg;
      out_startofpacket <= sop_pend;
      out_endofpacket   <= eop_pend;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sfpp_reconfig_b2p_decoder.sv
// tb/tb_sfpp_reconfig_b2p_decoder.sv - directed table-driven bench for the bytes-to-packets decoder
module tb_sfpp_reconfig_b2p_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [7:0]  out_channel;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic        out_ready;
  logic [15:0] drop_count;

  logic        sat_in_valid;
  logic [7:0]  sat_in_data;
  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_data;
  logic [7:0]  sat_out_channel;
  logic        sat_out_sop;
  logic        sat_out_eop;
  logic        sat_out_ready;
  logic [3:0]  sat_drop_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sfpp_reconfig_b2p_decoder #(.CHANNEL_WIDTH(8), .DROP_CNT_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_ready         (out_ready),
    .drop_count        (drop_count)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  sfpp_reconfig_b2p_decoder #(.CHANNEL_WIDTH(8), .DROP_CNT_WIDTH(4)) dut_sat (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (sat_in_valid),
    .in_data           (sat_in_data),
    .in_ready          (sat_in_ready),
    .out_valid         (sat_out_valid),
    .out_data          (sat_out_data),
    .out_channel       (sat_out_channel),
    .out_startofpacket (sat_out_sop),
    .out_endofpacket   (sat_out_eop),
    .out_ready         (sat_out_ready),
    .drop_count        (sat_drop_count)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_d;
    logic        e_sop;
    logic        e_eop;
    logic [7:0]  e_ch;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic e_ir, logic e_ov,
                              logic [7:0] e_d, logic e_sop, logic e_eop, logic [7:0] e_ch,
                              logic [15:0] e_drop);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_d = e_d; v.e_sop = e_sop; v.e_eop = e_eop; v.e_ch = e_ch; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and the
  // registered outputs after it.
  task automatic step(vec_t v, int idx);
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    #1;
    chk($sformatf("in_ready[%0d]", idx), {31'd0, in_ready}, {31'd0, v.e_ir});
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", idx), {31'd0, out_valid}, {31'd0, v.e_ov});
    if (v.e_ov) begin
      chk($sformatf("out_data[%0d]", idx), {24'd0, out_data}, {24'd0, v.e_d});
      chk($sformatf("sop[%0d]", idx), {31'd0, out_startofpacket}, {31'd0, v.e_sop});
      chk($sformatf("eop[%0d]", idx), {31'd0, out_endofpacket}, {31'd0, v.e_eop});
      chk($sformatf("channel[%0d]", idx), {24'd0, out_channel}, {24'd0, v.e_ch});
    end
    chk($sformatf("drop_count[%0d]", idx), {16'd0, drop_count}, {16'd0, v.e_drop});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_out_channel"}, {24'd0, out_channel}, 32'd0);
    chk({tag, "_sop"}, {31'd0, out_startofpacket}, 32'd0);
    chk({tag, "_eop"}, {31'd0, out_endofpacket}, 32'd0);
    chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    out_ready     = 1'b1;
    sat_in_valid  = 1'b0;
    sat_in_data   = 8'h00;
    sat_out_ready = 1'b1;

    // Basic packet with channel: 7A 7C 03 11 22 7B 33
    vecs.push_back(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h7C, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h03, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h11, 1, 1, 1, 8'h11, 1, 0, 8'h03, 16'd0));
    vecs.push_back(mk(1, 8'h22, 1, 1, 1, 8'h22, 0, 0, 8'h03, 16'd0));
    vecs.push_back(mk(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h33, 1, 1, 1, 8'h33, 0, 1, 8'h03, 16'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    // Escaped markers are data: 7A 7D 5A 7B 7D 5D
    vecs.push_back(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h5A, 1, 1, 1, 8'h7A, 1, 0, 8'h03, 16'd0));
    vecs.push_back(mk(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    vecs.push_back(mk(1, 8'h5D, 1, 1, 1, 8'h7D, 0, 1, 8'h03, 16'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd0));
    // Out-of-packet drops then a 1-byte packet: 44 55 7A 7B 66
    vecs.push_back(mk(1, 8'h44, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd1));
    vecs.push_back(mk(1, 8'h55, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h66, 1, 1, 1, 8'h66, 1, 1, 8'h03, 16'd2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    // Escaped channel value then backpressure: 7A 7C 7D 5C 01, stall 3, release
    vecs.push_back(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h7C, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h5C, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h01, 0, 1, 1, 8'h01, 1, 0, 8'h7C, 16'd2));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 1, 0, 8'h7C, 16'd2));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 1, 0, 8'h7C, 16'd2));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 1, 0, 8'h7C, 16'd2));
    vecs.push_back(mk(1, 8'h02, 1, 1, 1, 8'h02, 0, 0, 8'h7C, 16'd2));
    vecs.push_back(mk(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));
    vecs.push_back(mk(1, 8'h03, 1, 1, 1, 8'h03, 0, 1, 8'h7C, 16'd2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2));

    do_reset();
    chk_reset_state("reset0");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Reset mid-escape: 7A 7D, reset, 5A must be dropped in NORMAL state.
    step(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2), 100);
    step(mk(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd2), 101);
    do_reset();
    chk_reset_state("reset1");
    step(mk(1, 8'h5A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd1), 102);
    step(mk(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd1), 103);
    step(mk(1, 8'h11, 1, 1, 1, 8'h11, 1, 0, 8'h00, 16'd1), 104);
    step(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 16'd1), 105);

    // Saturation on the 4-bit counter instance: reach all-ones minus 1, then 3 more.
    for (int i = 0; i < 14; i++) begin
      sat_in_valid = 1'b1;
      sat_in_data  = 8'h44;
      @(posedge clk);
      #1;
    end
    chk("sat_pre", {28'd0, sat_drop_count}, 32'd14);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_%0d", i), {28'd0, sat_drop_count}, 32'd15);
    end
    sat_in_valid = 1'b0;
    chk("sat_out_valid", {31'd0, sat_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfpp_reconfig_b2p_decoder.md
# sfpp_reconfig_b2p_decoder

Bytes-to-packets decoder for the reconfig master's byte command path. It consumes the 8-bit Avalon-ST byte stream produced by the reconfig master's timing adapter and strips the in-band framing markers: 0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape. It emits one packetised data byte per handshake, with start/end-of-packet and channel sideband, to the downstream packet-to-transaction stage. Out-of-packet data bytes are dropped and counted.

## Interface
- CHANNEL_WIDTH, 8: width of out_channel; the decoded channel byte is truncated to the low CHANNEL_WIDTH bits.
- DROP_CNT_WIDTH, 16: width of the saturating drop counter.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  framed byte stream.
- in_ready  out  1  decoder accepts in_data this cycle.
- out_valid  out  1  decoded data byte present.
- out_data  out  8  decoded (unescaped) data byte.
- out_channel  out  CHANNEL_WIDTH  channel of current byte.
- out_startofpacket  out  1  first byte of packet.
- out_endofpacket  out  1  last byte of packet.
- out_ready  in  1  downstream accepts output.
- drop_count  out  DROP_CNT_WIDTH  saturating count of discarded out-of-packet data bytes.

## Operation
- Accept on in_valid && in_ready. Byte classification in state NORMAL:
  - 0x7A sets sop_pend.
  - 0x7B sets eop_pend.
  - 0x7C moves to CHAN.
  - 0x7D moves to ESC.
  - Any other byte is a data byte.
- ESC: the next accepted byte XOR 0x20 is a data byte; return to NORMAL. Marker values are not interpreted in ESC.
- CHAN: the next accepted byte is the channel value, loaded into the channel register; return to NORMAL. If that byte is 0x7D, go to CHAN_ESC instead; the following byte XOR 0x20 is the channel value, then return to NORMAL.
- Data byte handling:
  - Emitted iff in_packet || sop_pend.
  - Emitted byte carries sop = sop_pend and eop = eop_pend, then clears both flags.
  - Emission with sop sets in_packet; emission with eop clears in_packet. Both sop and eop on one byte means a 1-byte packet and in_packet ends at 0.
  - A data byte that is not emitted is dropped: drop_count increments and saturates at all-ones. A dropped byte also clears eop_pend.
- Repeated markers:
  - Repeated 0x7A while sop_pend is set: idempotent.
  - 0x7A while in_packet: sop_pend set. The next byte starts a new packet; no synthetic EOP is generated.
- Markers and channel bytes produce no output.
- out_channel is the channel register value captured with each emitted byte; it holds between packets.

## Timing
- Output register stage: in_ready = !out_valid || out_ready (combinational from out_ready).
- An accepted data byte appears on out_valid the next cycle. Latency is 1 cycle; throughput is 1 byte/cycle under continuous out_ready.
- out_valid, out_data, out_channel and the sop/eop outputs hold stable while out_valid && !out_ready.
- Control bytes are consumed at 1 per cycle regardless of out_ready if out_valid=0; otherwise they are gated by in_ready like data.
- Values after reset:
  - Outputs: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, drop_count=0. in_ready=1 (no data held, since out_valid=0).
  - Internal: state=NORMAL, sop_pend=0, eop_pend=0, in_packet=0, channel register 0.
- Reset mid-packet or mid-escape discards the held byte and all pending state. There is no recovery of a partial packet.
- Simultaneous output handshake and new accepted byte: the register reloads in the same cycle, with no bubble.
- in_valid low in ESC/CHAN/CHAN_ESC: the state holds indefinitely.

## Structure
- Shared package sfpp_reconfig_pkg: marker constants (SOP 8'h7A, EOP 8'h7B, CHAN 8'h7C, ESC 8'h7D, XOR mask 8'h20) and the decoder state enum (NORMAL, ESC, CHAN, CHAN_ESC). The packet-to-bytes encoder reuses these.
- Single module. The output register is simple enough to stay inline, so no sub-module.

## Test plan
- Stream 7A 7C 03 11 22 7B 33 with out_ready=1 -> three outputs: 11 (sop, ch 3), 22, 33 (eop, ch 3). Each appears 1 cycle after its input; drop_count=0.
- Stream 7A 7D 5A 7B 7D 5D -> outputs 7A (sop) and 7D (eop); no marker is interpreted.
- Stream 44 55 7A 7B 66 with no prior SOP -> 44 and 55 are dropped (drop_count=2); 66 is emitted with sop=1 and eop=1.
- Stream 7A 7C 7D 5C 01 -> channel 7C, output 01 with sop=1. Hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable; release -> handshake.
- Force drop_count to all-ones minus 1, then send 3 out-of-packet bytes -> drop_count saturates at FFFF.
- Stream 7A 7D, then assert reset for 1 cycle, then send 5A -> 5A is dropped (drop_count=1) and the state returns to NORMAL.
